// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer: issues one register-file instruction at a time to an
// external registered ALU, writes the result back and reports it.
// Every instruction takes IDLE -> ISSUE -> WB -> IDLE. Operands are
// captured when the instruction is accepted. The result is written
// back, and the result strobe raised, on the edge that ends WB.
module alu_op_sequencer #(
  parameter bit WIDE_MUL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  input  logic        ld_valid,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [3:0]  alu_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_z,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [2:0]  res_rd,
  output logic        div_err,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  regs [8];
  logic [2:0]  rd_q;
  logic [2:0]  rd_hi;
  logic        accept;
  logic        load;
  logic        div_zero;
  logic        wide_wr;

  assign accept   = in_valid && in_ready;
  assign load     = (state == IDLE) && ld_valid;
  assign div_zero = (alu_sel == OP_DIV) && (alu_b == 8'h00);
  assign rd_hi    = rd_q + 3'd1;
  // The high product byte goes to rd+1. With rd==7 it is dropped rather than wrapped to r0.
  assign wide_wr  = WIDE_MUL && (alu_sel == OP_MUL) && (rd_q != 3'd7);
  assign dbg_data = regs[dbg_addr];

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, handshake and busy decode.
  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // A preload wins over an instruction. Nothing is accepted while reset is asserted.
        in_ready = !ld_valid && !rst;
        if (in_valid && !ld_valid && !rst) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch op, rd and operand values on acceptance. They drive the ALU until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel <= 4'h0;
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      rd_q    <= 3'd0;
    end else if (accept) begin
      alu_sel <= in_op;
      alu_a   <= regs[in_rs1];
      alu_b   <= regs[in_rs2];
      rd_q    <= in_rd;
    end
  end

  // Register file. A preload in IDLE writes it, and so does writeback at the end of WB.
  // NOTE: the register array is reset explicitly, because every register must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (load) begin
      regs[ld_addr] <= ld_data;
    end else if (state == WB && !div_zero) begin
      regs[rd_q] <= alu_z[7:0];
      if (wide_wr) regs[rd_hi] <= alu_z[15:8];
    end
  end

  // Result reporting. This is a one-cycle strobe after WB. res_data and res_rd hold between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      div_err   <= 1'b0;
      res_data  <= 16'h0000;
      res_rd    <= 3'd0;
    end else begin
      res_valid <= 1'b0;
      div_err   <= 1'b0;
      if (state == WB) begin
        if (div_zero) begin
          div_err <= 1'b1;
        end else begin
          res_valid <= 1'b1;
          res_data  <= alu_z;
          res_rd    <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for alu_op_sequencer. A behavioural registered ALU
// drives alu_z. A register-array model predicts results, strobes and writebacks.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_z;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        div_err;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  m_regs [8];
  logic [15:0] m_last_data;
  logic [2:0]  m_last_rd;

  alu_op_sequencer #(.WIDE_MUL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .div_err(div_err), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural ALU: 0 ADD, 1 SUB, 2 MUL, 3 DIV, ... F EQ.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a - b);
      4'h2: return 16'(a) * 16'(b);
      4'h3: return (b == 8'h00) ? 16'hFFFF : {a % b, a / b};
      4'h4: return 16'(a & b);
      4'h5: return 16'(a | b);
      4'h6: return 16'(a ^ b);
      4'h7: return 16'(~a);
      4'h8: return 16'(a) << 1;
      4'h9: return 16'(a >> 1);
      4'hF: return 16'(a == b);
      default: return {a, b};
    endcase
  endfunction

  // Registered ALU: the result appears one cycle after the operands.
  always @(posedge clk) alu_z <= alu_fn(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [2:0] addr, input string tag);
    dbg_addr = addr;
    #1;
    check(tag, 16'(dbg_data), 16'(m_regs[addr]));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) read_reg(3'(i), tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_last_data = 16'h0000;
    m_last_rd   = 3'd0;
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    #1;
    check("ld_blocks_ready", 16'(in_ready), 16'd0);
    tick();
    ld_valid = 1'b0;
    m_regs[addr] = data;
    read_reg(addr, "ld_write");
  endtask

  // Offer one instruction in an IDLE cycle and follow it through k+1..k+3.
  // hold keeps in_valid high after acceptance. noise drives stray preloads during ISSUE/WB.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit hold, input bit noise);
    logic [15:0] exp;
    logic [7:0]  a, b;
    logic [2:0]  hi;
    bit          dz;
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    exp = alu_fn(op, a, b);
    dz  = (op == 4'h3) && (b == 8'h00);
    hi  = rd + 3'd1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_valid = 1'b1;
    #1;
    check("ready_idle", 16'(in_ready), 16'd1);
    tick();                                   // ISSUE, cycle k+1
    if (!hold) in_valid = 1'b0;
    if (noise) begin
      ld_valid = 1'b1;
      ld_addr  = rd ^ 3'd2;
      ld_data  = 8'hA5;
    end
    #1;
    check("issue_busy", 16'(busy), 16'd1);
    check("issue_ready", 16'(in_ready), 16'd0);
    check("issue_strobe", 16'({res_valid, div_err}), 16'd0);
    check("alu_sel", 16'(alu_sel), 16'(op));
    check("alu_a", 16'(alu_a), 16'(a));
    check("alu_b", 16'(alu_b), 16'(b));
    tick();                                   // WB, cycle k+2
    check("wb_busy", 16'(busy), 16'd1);
    check("wb_no_result", 16'(res_valid), 16'd0);
    check("wb_alu_a_stable", 16'(alu_a), 16'(a));
    tick();                                   // result, cycle k+3
    ld_valid = 1'b0;
    #1;
    check("res_valid", 16'(res_valid), dz ? 16'd0 : 16'd1);
    check("div_err", 16'(div_err), dz ? 16'd1 : 16'd0);
    check("done_busy", 16'(busy), 16'd0);
    check("done_ready", 16'(in_ready), 16'd1);
    if (!dz) begin
      m_last_data = exp;
      m_last_rd   = rd;
      m_regs[rd]  = exp[7:0];
      if (op == 4'h2 && rd != 3'd7) m_regs[hi] = exp[15:8];
    end
    check("res_data", res_data, m_last_data);
    check("res_rd", 16'(res_rd), 16'(m_last_rd));
    read_reg(rd, "wb_rd");
    read_reg(hi, "wb_rd_plus1");
    if (noise) read_reg(rd ^ 3'd2, "ld_ignored_busy");
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 8'h00; dbg_addr = 3'd0;
    model_reset();

    // Reset state. in_ready stays low while rst is high, even in IDLE.
    tick(); tick();
    check("rst_ready", 16'(in_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_strobes", 16'({res_valid, div_err}), 16'd0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_alu", {alu_sel, alu_a[3:0], alu_b}, 16'h0000);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 16'(in_ready), 16'd1);
    check_regs("rst_regs");

    // ADD: 0C + 03 = 000F into r3.
    do_load(3'd1, 8'h0C);
    do_load(3'd2, 8'h03);
    issue(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
    check("add_value", 16'(m_regs[3]), 16'h000F);

    // Wide MUL: C8 * 02 = 0190 into r4/r5. Then rd=7 must leave r0 untouched.
    do_load(3'd0, 8'h5A);
    do_load(3'd1, 8'hC8);
    do_load(3'd2, 8'h02);
    issue(4'h2, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
    issue(4'h2, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0);
    check_regs("mul_regs");

    // Divide by zero: a div_err pulse only, with no write and no result.
    do_load(3'd2, 8'h00);
    issue(4'h3, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0);
    check_regs("div0_regs");

    // Back-to-back with in_valid held high. The second instruction reads the new r3.
    do_load(3'd1, 8'h40);
    do_load(3'd2, 8'h11);
    issue(4'h1, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
    issue(4'h0, 3'd4, 3'd3, 3'd3, 1'b0, 1'b0);

    // Preload and instruction together: the load wins, and the instruction is taken next cycle.
    in_op = 4'h0; in_rd = 3'd6; in_rs1 = 3'd6; in_rs2 = 3'd1; in_valid = 1'b1;
    do_load(3'd6, 8'h21);
    check("ld_then_idle", 16'(busy), 16'd0);
    issue(4'h0, 3'd6, 3'd6, 3'd1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end else begin
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(2, 3));
        issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'b0, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Reset during WB of ADD rd=6 aborts the instruction.
    do_load(3'd1, 8'h12);
    do_load(3'd2, 8'h34);
    in_op = 4'h0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2; in_valid = 1'b1;
    tick();                                   // ISSUE
    in_valid = 1'b0;
    tick();                                   // WB
    rst = 1'b1;
    #1;
    check("rst_wb_ready", 16'(in_ready), 16'd0);
    tick();
    rst = 1'b0;
    #1;
    model_reset();
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_ready", 16'(in_ready), 16'd1);
    check("abort_strobes", 16'({res_valid, div_err}), 16'd0);
    check("abort_res_data", res_data, 16'h0000);
    check_regs("abort_regs");
    tick();
    check("abort_no_late_strobe", 16'({res_valid, div_err}), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: WIDE_MUL, default 1; when 1, MUL (op 4'h2) also writes Z[15:8] to register rd+1.
REQ-002 The block SHALL use a single clock, clk, with reset rst; rst SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  instruction accepted when in_valid && in_ready at a rising edge.
REQ-007 in_op  input  4  ALU select code (0 ADD … F EQ, same encoding as ALU sel).
REQ-008 in_rd / in_rs1 / in_rs2  input  3 each  destination / source register indices.
REQ-009 ld_valid, ld_addr[2:0], ld_data[7:0]  input  register preload port.
REQ-010 alu_sel[3:0], alu_a[7:0], alu_b[7:0]  output  operands driven to the registered ALU.
REQ-011 alu_z  input  16  registered ALU result, valid one cycle after operands are presented.
REQ-012 res_valid  output  1  one-cycle result strobe; res_data[15:0], res_rd[2:0] outputs accompany it.
REQ-013 div_err  output  1  one-cycle strobe, divide by zero detected.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 dbg_addr[2:0] input, dbg_data[7:0] output  combinational register-file read.

Function
REQ-016 Register file: 8 x 8-bit, r0..r7, all writable (no hard-wired zero).
REQ-017 FSM states IDLE, ISSUE, WB; IDLE->ISSUE on accepted instruction; ISSUE->WB unconditionally; WB->IDLE unconditionally.
REQ-018 in_ready SHALL be high only in IDLE with ld_valid low.
REQ-019 On acceptance, op, rd, and operand values rs1/rs2 SHALL be latched; alu_sel/alu_a/alu_b driven from latches, held stable through ISSUE and WB.
REQ-020 ld_valid in IDLE writes ld_data to r[ld_addr] at the edge and has priority over in_valid; ld_valid outside IDLE SHALL be ignored.
REQ-021 In WB, alu_z SHALL be sampled; at the WB-ending edge r[rd] <= alu_z[7:0]; if op==2, WIDE_MUL==1 and rd!=7, r[rd+1] <= alu_z[15:8]; rd==7 writes low byte only (no wrap to r0).
REQ-022 Cycle after WB: res_valid=1 for exactly one cycle, res_data=alu_z as sampled in WB, res_rd=rd; in_ready high in that same cycle.
REQ-023 Latency: instruction accepted at edge k -> ISSUE cycle k+1, WB cycle k+2, res_valid cycle k+3; max throughput one instruction per 3 cycles.
REQ-024 Divide by zero (op 3, latched B==0): no register write, res_valid stays 0, div_err=1 in cycle k+3 instead; FSM timing unchanged.
REQ-025 Source equals destination of the previous instruction SHALL read the written-back value (write completes before next acceptance).
REQ-026 res_data/res_rd SHALL hold last value when res_valid is low.

Reset
REQ-027 rst at any edge: state=IDLE, r0..r7=0, alu_sel/alu_a/alu_b=0, res_valid=0, res_data=0, res_rd=0, div_err=0, busy=0.
REQ-028 rst asserted in ISSUE or WB SHALL abort the instruction: no register write, no res_valid, no div_err.
REQ-029 in_ready SHALL be 0 in the cycle rst is high.

Verification
REQ-030 Load r1=8'h0C, r2=8'h03; issue ADD rd=3 -> res_valid at k+3, res_data=16'h000F, r3=8'h0F.
REQ-031 r1=8'hC8, r2=8'h02, MUL rd=4, WIDE_MUL=1 -> res_data=16'h0190, r4=8'h90, r5=8'h01; same with rd=7 -> r7=8'h90, r0 unchanged.
REQ-032 DIV with r2=0 -> div_err pulse at k+3, no res_valid, destination unchanged.
REQ-033 in_valid held high with back-to-back SUB r3=r1-r2 then ADD r4=r3+r3 -> accepts at edges k and k+3, second result uses updated r3.
REQ-034 ld_valid and in_valid both high in IDLE -> load performed, in_ready=0, instruction accepted next cycle.
REQ-035 rst pulsed during WB of ADD rd=6 -> r6=0, no res_valid, busy=0 and in_ready=1 the cycle after rst drops.
